// File: rtl/atomic_ctr_pkg.sv
// Shared types and defaults for the two-beat atomic counter arbiter.
package atomic_ctr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int DATA_BUS_DEF  = 32;
  localparam int COUNT_LEN_DEF = 64;

  function automatic int tmo_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  int w_j;

  // Walk from the farthest candidate to the nearest so the nearest hit is kept.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = PW'(w_j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atomic_counter_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters coherent two-beat reads
// of a 64-bit atomic counter slave, with a per-beat ack timeout.
module atomic_counter_arbiter
  import atomic_ctr_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DataBus  = DATA_BUS_DEF,
  parameter int CountLen = COUNT_LEN_DEF,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk_w,
  input  logic                reset_w,
  input  logic [NUM_REQ-1:0]  rd_req_w_i,
  output logic [NUM_REQ-1:0]  rd_gnt_w_o,
  output logic [NUM_REQ-1:0]  rd_valid_w_o,
  output logic                rd_err_w_o,
  output logic [CountLen-1:0] rd_data_w_o,
  output logic                ctr_req_w_o,
  output logic                ctr_atomic_w_o,
  input  logic                ctr_ack_w_i,
  input  logic [DataBus-1:0]  ctr_count_w_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = tmo_width(TIMEOUT);

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_valid;
  logic                r_err;
  logic [CountLen-1:0] r_data;
  logic                r_ctr_req;
  logic                r_ctr_atomic;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_idx;
  logic [TW-1:0]       r_tmo;

  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [PW-1:0]       w_pick_idx;
  logic                w_any;
  logic                w_tmo_hit;
  logic [PW-1:0]       w_next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .i_req (rd_req_w_i),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
  assign w_next_ptr = (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + PW'(1);

  always_ff @(posedge clk_w) begin
    if (!reset_w) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_valid      <= '0;
      r_err        <= 1'b0;
      r_data       <= '0;
      r_ctr_req    <= 1'b0;
      r_ctr_atomic <= 1'b0;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_tmo        <= '0;
    end else begin
      r_valid <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt        <= w_pick_gnt;
            r_idx        <= w_pick_idx;
            r_data       <= '0;
            r_err        <= 1'b0;
            r_tmo        <= '0;
            r_ctr_req    <= 1'b1;
            r_ctr_atomic <= 1'b1;
            r_state      <= ST_LO;
          end
        end
        ST_LO: begin
          // Ack takes priority over an expiring timeout in the same cycle.
          if (ctr_ack_w_i) begin
            r_data[DataBus-1:0] <= ctr_count_w_i;
            r_ctr_atomic        <= 1'b0;
            r_tmo               <= '0;
            r_state             <= ST_HI;
          end else if (w_tmo_hit) begin
            r_ctr_req    <= 1'b0;
            r_ctr_atomic <= 1'b0;
            r_err        <= 1'b1;
            r_valid      <= r_gnt;
            r_state      <= ST_RESP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_HI: begin
          if (ctr_ack_w_i) begin
            r_data[CountLen-1:DataBus] <= ctr_count_w_i;
            r_ctr_req                  <= 1'b0;
            r_err                      <= 1'b0;
            r_valid                    <= r_gnt;
            r_state                    <= ST_RESP;
          end else if (w_tmo_hit) begin
            r_ctr_req <= 1'b0;
            r_err     <= 1'b1;
            r_valid   <= r_gnt;
            r_state   <= ST_RESP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_RESP: begin
          r_err   <= 1'b0;
          r_gnt   <= '0;
          r_ptr   <= w_next_ptr;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_gnt_w_o     = r_gnt;
  assign rd_valid_w_o   = r_valid;
  assign rd_err_w_o     = r_err;
  assign rd_data_w_o    = r_data;
  assign ctr_req_w_o    = r_ctr_req;
  assign ctr_atomic_w_o = r_ctr_atomic;

endmodule

// File: tb/tb_atomic_counter_arbiter.sv
// Table-driven bench for atomic_counter_arbiter with a configurable-latency slave model.
module tb_atomic_counter_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic        clk_w;
  logic        reset_w;
  logic [3:0]  rd_req_w_i;
  logic [3:0]  rd_gnt_w_o;
  logic [3:0]  rd_valid_w_o;
  logic        rd_err_w_o;
  logic [63:0] rd_data_w_o;
  logic        ctr_req_w_o;
  logic        ctr_atomic_w_o;
  logic        ctr_ack_w_i;
  logic [31:0] ctr_count_w_i;

  atomic_counter_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DataBus  (32),
    .CountLen (64),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_w          (clk_w),
    .reset_w        (reset_w),
    .rd_req_w_i     (rd_req_w_i),
    .rd_gnt_w_o     (rd_gnt_w_o),
    .rd_valid_w_o   (rd_valid_w_o),
    .rd_err_w_o     (rd_err_w_o),
    .rd_data_w_o    (rd_data_w_o),
    .ctr_req_w_o    (ctr_req_w_o),
    .ctr_atomic_w_o (ctr_atomic_w_o),
    .ctr_ack_w_i    (ctr_ack_w_i),
    .ctr_count_w_i  (ctr_count_w_i)
  );

  initial clk_w = 1'b0;
  always #5 clk_w = ~clk_w;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] lo;
    logic [31:0] hi;
    int          hw;
    logic [3:0]  gnt;
    logic [63:0] data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl [10];

  int          checks;
  int          failures;
  logic [31:0] lo_val;
  logic [31:0] hi_val;
  int          hi_wait;
  int          beat_cnt;
  logic        force_ack;
  logic        atomic_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: outputs are sampled 1ns after the edge, slave ack for this cycle is driven.
  task automatic step();
    int w;
    @(posedge clk_w);
    #1;
    if (ctr_atomic_w_o && !ctr_req_w_o) atomic_bad = 1'b1;
    if (force_ack) begin
      ctr_ack_w_i   = 1'b1;
      ctr_count_w_i = 32'hDEAD_BEEF;
      force_ack     = 1'b0;
      beat_cnt      = 0;
    end else if (ctr_req_w_o) begin
      w = ctr_atomic_w_o ? 1 : hi_wait;
      if (beat_cnt >= w) begin
        ctr_ack_w_i   = 1'b1;
        ctr_count_w_i = ctr_atomic_w_o ? lo_val : hi_val;
        beat_cnt      = 0;
      end else begin
        ctr_ack_w_i   = 1'b0;
        ctr_count_w_i = 32'h0;
        beat_cnt++;
      end
    end else begin
      ctr_ack_w_i   = 1'b0;
      ctr_count_w_i = 32'h0;
      beat_cnt      = 0;
    end
  endtask

  task automatic do_reset();
    rd_req_w_i = 4'b0000;
    reset_w    = 1'b0;
    step();
    reset_w    = 1'b1;
  endtask

  task automatic run_txn(input string name, input logic [3:0] req, input logic [31:0] lo,
                         input logic [31:0] hi, input int hw, input logic drop,
                         input logic [3:0] egnt, input logic [63:0] edata,
                         input logic eerr, input int elat);
    int lat;
    rd_req_w_i = req;
    lo_val     = lo;
    hi_val     = hi;
    hi_wait    = hw;
    step();
    lat = 1;
    chk({name, " grant_next_cycle"}, 64'(rd_gnt_w_o), 64'(egnt));
    if (drop) rd_req_w_i = 4'b0000;
    while (rd_valid_w_o == 4'b0000 && lat < 200) begin
      step();
      lat++;
    end
    if (rd_valid_w_o == 4'b0000) begin
      chk({name, " valid_within_bound"}, 64'(0), 64'(1));
    end else begin
      $display("txn %s gnt=%b valid=%b data=%h err=%b lat=%0d",
               name, rd_gnt_w_o, rd_valid_w_o, rd_data_w_o, rd_err_w_o, lat);
      chk({name, " valid"}, 64'(rd_valid_w_o), 64'(egnt));
      chk({name, " gnt_held"}, 64'(rd_gnt_w_o), 64'(egnt));
      chk({name, " data"}, rd_data_w_o, edata);
      chk({name, " err"}, 64'(rd_err_w_o), 64'(eerr));
      chk({name, " latency"}, 64'(lat), 64'(elat));
    end
    step();
    chk({name, " pulse_end"}, 64'({rd_valid_w_o, rd_gnt_w_o, rd_err_w_o, ctr_req_w_o}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks        = 0;
    failures      = 0;
    lo_val        = 32'h0;
    hi_val        = 32'h0;
    hi_wait       = 1;
    beat_cnt      = 0;
    force_ack     = 1'b0;
    atomic_bad    = 1'b0;
    reset_w       = 1'b0;
    rd_req_w_i    = 4'b0000;
    ctr_ack_w_i   = 1'b0;
    ctr_count_w_i = 32'h0;

    //        rst   req      lo             hi             hw          gnt      data                      err  lat
    tbl[0] = '{1'b1, 4'b0001, 32'h0000_0005, 32'h0000_0001, 1,          4'b0001, 64'h0000_0001_0000_0005, 1'b0, 5};
    tbl[1] = '{1'b1, 4'b1111, 32'h0000_0010, 32'h0000_0020, 1,          4'b0001, 64'h0000_0020_0000_0010, 1'b0, 5};
    tbl[2] = '{1'b0, 4'b1111, 32'h0000_0011, 32'h0000_0021, 1,          4'b0010, 64'h0000_0021_0000_0011, 1'b0, 5};
    tbl[3] = '{1'b0, 4'b1111, 32'h0000_0012, 32'h0000_0022, 1,          4'b0100, 64'h0000_0022_0000_0012, 1'b0, 5};
    tbl[4] = '{1'b0, 4'b1111, 32'h0000_0013, 32'h0000_0023, 1,          4'b1000, 64'h0000_0023_0000_0013, 1'b0, 5};
    tbl[5] = '{1'b0, 4'b1111, 32'h0000_0014, 32'h0000_0024, 1,          4'b0001, 64'h0000_0024_0000_0014, 1'b0, 5};
    tbl[6] = '{1'b0, 4'b0100, 32'hAAAA_AAAA, 32'h5555_5555, 1000,       4'b0100, 64'h0000_0000_AAAA_AAAA, 1'b1, 3 + TIMEOUT};
    tbl[7] = '{1'b0, 4'b0100, 32'h0000_0007, 32'h0000_0008, 1,          4'b0100, 64'h0000_0008_0000_0007, 1'b0, 5};
    tbl[8] = '{1'b0, 4'b1010, 32'hFFFF_FFFF, 32'h1234_5678, TIMEOUT - 1, 4'b1000, 64'h1234_5678_FFFF_FFFF, 1'b0, 3 + TIMEOUT};
    tbl[9] = '{1'b0, 4'b1010, 32'h0000_0030, 32'h0000_0040, 1,          4'b0010, 64'h0000_0040_0000_0030, 1'b0, 5};

    step();
    step();
    chk("reset_state", {rd_data_w_o[59:0], rd_gnt_w_o}, 64'h0);
    chk("reset_ctrl", 64'({rd_valid_w_o, rd_err_w_o, ctr_req_w_o, ctr_atomic_w_o}), 64'h0);
    reset_w = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      run_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].lo, tbl[i].hi, tbl[i].hw, 1'b0,
              tbl[i].gnt, tbl[i].data, tbl[i].err, tbl[i].lat);
    end

    // Reset in the middle of the HI beat: abandoned silently, pointer back to 0.
    rd_req_w_i = 4'b0010;
    lo_val     = 32'h0000_0050;
    hi_val     = 32'h0000_0060;
    hi_wait    = 1000;
    step();
    step();
    step();
    chk("midhi_in_hi_beat", 64'({ctr_req_w_o, ctr_atomic_w_o, rd_gnt_w_o}), 64'({2'b10, 4'b0010}));
    rd_req_w_i = 4'b0000;
    reset_w    = 1'b0;
    step();
    reset_w    = 1'b1;
    chk("midhi_outputs_cleared", 64'({rd_gnt_w_o, rd_valid_w_o, rd_err_w_o, ctr_req_w_o, ctr_atomic_w_o}), 64'h0);
    chk("midhi_data_cleared", rd_data_w_o, 64'h0);
    step();
    step();
    chk("midhi_no_valid", 64'({rd_valid_w_o, ctr_req_w_o}), 64'h0);
    run_txn("after_reset_ptr0", 4'b0101, 32'h0000_0001, 32'h0000_0002, 1, 1'b0,
            4'b0001, 64'h0000_0002_0000_0001, 1'b0, 5);
    run_txn("after_reset_req2", 4'b0100, 32'h0000_0003, 32'h0000_0004, 1, 1'b0,
            4'b0100, 64'h0000_0004_0000_0003, 1'b0, 5);

    // Requester drops its request during LO; pointer then lands on index 2.
    run_txn("req_drop", 4'b0010, 32'hCAFE_0001, 32'hBEEF_0002, 1, 1'b1,
            4'b0010, 64'hBEEF_0002_CAFE_0001, 1'b0, 5);
    run_txn("ptr_after_drop", 4'b1110, 32'h0000_0009, 32'h0000_000A, 1, 1'b0,
            4'b0100, 64'h0000_000A_0000_0009, 1'b0, 5);

    // Stray ack while idle must be ignored.
    rd_req_w_i = 4'b0000;
    force_ack  = 1'b1;
    step();
    step();
    chk("stray_ack_idle", 64'({rd_gnt_w_o, rd_valid_w_o, rd_err_w_o, ctr_req_w_o, ctr_atomic_w_o}), 64'h0);
    step();
    chk("stray_ack_idle_data", rd_data_w_o, 64'h0000_000A_0000_0009);
    run_txn("after_stray", 4'b1111, 32'h0000_0B0B, 32'h0000_0C0C, 1, 1'b0,
            4'b1000, 64'h0000_0C0C_0000_0B0B, 1'b0, 5);

    chk("atomic_only_with_req", 64'(atomic_bad), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
